// File: rtl/Pipe_Buf_Reg_PKG.sv
// Shared pipeline types: branch-predictor entry state and counter encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package Pipe_Buf_Reg_PKG;

  // 2-bit saturating counter states; the MSB is the taken prediction.
  localparam logic [1:0] BP_CTR_SNT = 2'b00;
  localparam logic [1:0] BP_CTR_WNT = 2'b01;
  localparam logic [1:0] BP_CTR_WT  = 2'b10;
  localparam logic [1:0] BP_CTR_ST  = 2'b11;

  // Per-entry control state. Tag and target widths depend on the
  // instantiating module's PC_W/ENTRIES, so those fields sit in parallel
  // parameter-sized arrays next to this struct rather than inside it.
  typedef struct packed {
    logic       valid;
    logic [1:0] ctr;
  } bp_entry_t;

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating counter next-state: +1 on taken, -1 on not taken, forced strong-taken for jumps.
// Latency: combinational.
// Backpressure: none.
module bp_sat_ctr
  import Pipe_Buf_Reg_PKG::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  input  logic       force_st,
  output logic [1:0] next_ctr
);

  // Saturate at strong-taken / strong-not-taken; force wins over direction.
  always_comb begin
    next_ctr = ctr;
    if (force_st) begin
      next_ctr = BP_CTR_ST;
    end else if (taken) begin
      if (ctr != BP_CTR_ST) next_ctr = ctr + 2'd1;
    end else begin
      if (ctr != BP_CTR_SNT) next_ctr = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Tagged BTB + 2-bit bimodal predictor; optional gshare indexing via macro BP_GSHARE_EN.
// Latency: lookup is zero-cycle (combinational from table flops); updates visible next cycle.
// Backpressure: none; one lookup and one update accepted every cycle.
module branch_predictor
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,   // power of two, >= 2
  parameter int GHR_W   = 4     // 1..$clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  input  logic             upd_is_jump,
  input  logic [GHR_W-1:0] upd_ghr
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int TAG_W  = PC_W - IDX_W - 2;
  // A zero-width tag is stored as a constant 1-bit zero so compares always match.
  localparam int TAG_WS = (TAG_W > 0) ? TAG_W : 1;

  logic [IDX_W-1:0]  look_base, upd_base, look_idx, upd_idx;
  logic [TAG_WS-1:0] look_tag, upd_tag;
  logic [PC_W-1:0]   pc_plus4;
  logic              upd_hit;
  logic [1:0]        upd_ctr, upd_ctr_next;
  logic              unused_bits;

  bp_entry_t         ent_q [ENTRIES];
  logic [TAG_WS-1:0] tag_q [ENTRIES];
  logic [PC_W-1:0]   tgt_q [ENTRIES];

  // Word-aligned PCs: bits [1:0] never participate in index or tag.
  assign look_base = if_pc[IDX_W+1:2];
  assign upd_base  = upd_pc[IDX_W+1:2];

  generate
    if (TAG_W > 0) begin : g_tag
      assign look_tag = if_pc[PC_W-1:IDX_W+2];
      assign upd_tag  = upd_pc[PC_W-1:IDX_W+2];
    end else begin : g_notag
      assign look_tag = '0;
      assign upd_tag  = '0;
    end
  endgenerate

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  // History shifts only on conditional-branch resolution; jumps carry no direction info.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
    end else if (upd_valid && !upd_is_jump) begin
      ghr <= GHR_W'({ghr, upd_taken});
    end
  end

  // Update re-derives the lookup index from the history the instruction was fetched with.
  assign look_idx    = look_base ^ IDX_W'(ghr);
  assign upd_idx     = upd_base ^ IDX_W'(upd_ghr);
  assign pred_ghr    = ghr;
  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0]};
`else
  assign look_idx    = look_base;
  assign upd_idx     = upd_base;
  assign pred_ghr    = '0;
  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0], upd_ghr};
`endif

  // Lookup reads registered state only, so a same-cycle update is not forwarded.
  assign pc_plus4    = if_pc + PC_W'(4);
  assign pred_hit    = ent_q[look_idx].valid && (tag_q[look_idx] == look_tag);
  assign pred_taken  = pred_hit && ent_q[look_idx].ctr[1];
  assign pred_target = pred_taken ? tgt_q[look_idx] : pc_plus4;

  assign upd_hit = ent_q[upd_idx].valid && (tag_q[upd_idx] == upd_tag);
  assign upd_ctr = ent_q[upd_idx].ctr;

  bp_sat_ctr u_sat_ctr (
    .ctr      (upd_ctr),
    .taken    (upd_taken),
    .force_st (upd_is_jump),
    .next_ctr (upd_ctr_next)
  );

  // Table write: train on hit, allocate on taken miss, ignore not-taken miss.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_q[i] <= '{valid: 1'b0, ctr: BP_CTR_WNT};
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        ent_q[upd_idx].ctr <= upd_ctr_next;
        if (upd_taken) tgt_q[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        ent_q[upd_idx] <= '{valid: 1'b1, ctr: (upd_is_jump ? BP_CTR_ST : BP_CTR_WT)};
        tag_q[upd_idx] <= upd_tag;
        tgt_q[upd_idx] <= upd_target;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (PC_W=9, ENTRIES=16, GHR_W=4).
// Latency: lookups checked in the same cycle they are driven.
// Backpressure: n/a.
module tb_branch_predictor;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] if_pc, pred_target, upd_pc, upd_target;
  logic       pred_hit, pred_taken, upd_valid, upd_taken, upd_is_jump;
  logic [3:0] pred_ghr, upd_ghr;

  always #5 clk = ~clk;

  branch_predictor #(.PC_W(9), .ENTRIES(16), .GHR_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .if_pc       (if_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .pred_ghr    (pred_ghr),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_is_jump (upd_is_jump),
    .upd_ghr     (upd_ghr)
  );

  typedef struct {
    logic       hit;
    logic       taken;
    logic [8:0] tgt;
    logic [3:0] ghr;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference table used for the random phase (non-gshare indexing).
  logic       m_v   [16];
  logic [2:0] m_tag [16];
  logic [8:0] m_tg  [16];
  logic [1:0] m_c   [16];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Drive one cycle of lookup + optional update; optionally queue and check the lookup.
  task automatic cyc(input logic [8:0] lpc, input logic uv, input logic [8:0] upc,
                     input logic ut, input logic [8:0] utg, input logic uj, input logic [3:0] ug,
                     input logic ck, input logic eh, input logic et, input logic [8:0] etg,
                     input logic [3:0] eg, input string nm);
    exp_t e;
    @(negedge clk);
    if_pc       = lpc;
    upd_valid   = uv;
    upd_pc      = upc;
    upd_taken   = ut;
    upd_target  = utg;
    upd_is_jump = uj;
    upd_ghr     = ug;
    if (ck) sb.push_back('{hit: eh, taken: et, tgt: etg, ghr: eg, nm: nm});
    #2;
    if (ck) begin
      e = sb.pop_front();
      check_val({e.nm, "/hit"},    32'(pred_hit),    32'(e.hit));
      check_val({e.nm, "/taken"},  32'(pred_taken),  32'(e.taken));
      check_val({e.nm, "/target"}, 32'(pred_target), 32'(e.tgt));
      check_val({e.nm, "/ghr"},    32'(pred_ghr),    32'(e.ghr));
    end
    @(posedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 1'b0; m_tag[i] = '0; m_tg[i] = '0; m_c[i] = 2'b01;
    end
  endtask

  task automatic model_update(input logic [8:0] pc, input logic t, input logic [8:0] tg, input logic j);
    int i;
    i = int'(pc[5:2]);
    if (m_v[i] && m_tag[i] == pc[8:6]) begin
      if (j)                    m_c[i] = 2'b11;
      else if (t && m_c[i] != 2'b11) m_c[i] = m_c[i] + 2'd1;
      else if (!t && m_c[i] != 2'b00) m_c[i] = m_c[i] - 2'd1;
      if (t) m_tg[i] = tg;
    end else if (t) begin
      m_v[i] = 1'b1; m_tag[i] = pc[8:6]; m_tg[i] = tg; m_c[i] = j ? 2'b11 : 2'b10;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    // An update during reset must be ignored.
    cyc(9'h010, 1'b1, 9'h010, 1'b1, 9'h040, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 9'h0, 4'h0, "rst");
    cyc(9'h010, 1'b1, 9'h010, 1'b1, 9'h040, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 9'h0, 4'h0, "rst");
    #1 reset = 1'b0;
  endtask

  logic [8:0] pool [8] = '{9'h010, 9'h050, 9'h0A0, 9'h1FC, 9'h0C0, 9'h044, 9'h144, 9'h004};

  initial begin
    reset = 1'b1; if_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_is_jump = 1'b0; upd_ghr = '0;
    do_reset();
    cyc(9'h010, 0, 9'h010, 1, 9'h040, 0, 4'h0, 1, 0, 0, 9'h014, 4'h0, "after_reset");

`ifdef BP_GSHARE_EN
    cyc(9'h1FC, 1, 9'h100, 1, 9'h020, 0, 4'h0, 0, 0, 0, 9'h000, 4'h0, "g1");
    cyc(9'h1FC, 1, 9'h100, 0, 9'h020, 0, 4'h0, 0, 0, 0, 9'h000, 4'h0, "g2");
    cyc(9'h1FC, 1, 9'h100, 1, 9'h020, 0, 4'h0, 0, 0, 0, 9'h000, 4'h0, "g3");
    cyc(9'h1FC, 1, 9'h010, 1, 9'h040, 1, 4'h5, 1, 0, 0, 9'h000, 4'h5, "ghr_0101");
    cyc(9'h010, 1, 9'h1C0, 0, 9'h000, 0, 4'h0, 1, 1, 1, 9'h040, 4'h5, "gs_hit");
    cyc(9'h010, 0, 9'h010, 0, 9'h000, 0, 4'h0, 1, 0, 0, 9'h014, 4'hA, "gs_miss");
`else
    cyc(9'h010, 1, 9'h010, 1, 9'h040, 0, 4'h0, 1, 0, 0, 9'h014, 4'h0, "same_cyc");
    cyc(9'h010, 1, 9'h010, 0, 9'h000, 0, 4'h0, 1, 1, 1, 9'h040, 4'h0, "trained");
    cyc(9'h010, 1, 9'h010, 0, 9'h000, 0, 4'h0, 1, 1, 0, 9'h014, 4'h0, "one_nt");
    cyc(9'h010, 0, 9'h010, 1, 9'h1E0, 1, 4'h0, 1, 1, 0, 9'h014, 4'h0, "two_nt");
    cyc(9'h010, 1, 9'h010, 1, 9'h040, 0, 4'h0, 1, 1, 0, 9'h014, 4'h0, "t1");
    cyc(9'h010, 1, 9'h010, 1, 9'h040, 0, 4'h0, 1, 1, 0, 9'h014, 4'h0, "t2");
    cyc(9'h010, 1, 9'h010, 1, 9'h040, 0, 4'h0, 1, 1, 1, 9'h040, 4'h0, "t3");
    cyc(9'h010, 1, 9'h010, 1, 9'h040, 0, 4'h0, 1, 1, 1, 9'h040, 4'h0, "t4");
    cyc(9'h010, 1, 9'h010, 0, 9'h000, 0, 4'h0, 1, 1, 1, 9'h040, 4'h0, "sat_nt");
    cyc(9'h010, 0, 9'h000, 0, 9'h000, 0, 4'h0, 1, 1, 1, 9'h040, 4'h0, "sat_then_nt");
    cyc(9'h050, 1, 9'h050, 1, 9'h100, 0, 4'h0, 1, 0, 0, 9'h054, 4'h0, "alias_pre");
    cyc(9'h010, 0, 9'h000, 0, 9'h000, 0, 4'h0, 1, 0, 0, 9'h014, 4'h0, "alias_old");
    cyc(9'h050, 0, 9'h000, 0, 9'h000, 0, 4'h0, 1, 1, 1, 9'h100, 4'h0, "alias_new");
    cyc(9'h0A0, 1, 9'h0A0, 0, 9'h000, 0, 4'h0, 1, 0, 0, 9'h0A4, 4'h0, "miss_nt");
    cyc(9'h0A0, 0, 9'h000, 0, 9'h000, 0, 4'h0, 1, 0, 0, 9'h0A4, 4'h0, "miss_nt_hold");
    cyc(9'h1FC, 1, 9'h0C0, 1, 9'h080, 0, 4'h0, 1, 0, 0, 9'h000, 4'h0, "wrap");
    cyc(9'h0C0, 1, 9'h0C0, 0, 9'h000, 0, 4'h0, 1, 1, 1, 9'h080, 4'h0, "c0_alloc");
    cyc(9'h0C0, 1, 9'h0C0, 0, 9'h1F0, 1, 4'h0, 1, 1, 0, 9'h0C4, 4'h0, "c0_weak");
    cyc(9'h0C0, 1, 9'h0A0, 1, 9'h1F0, 1, 4'h0, 1, 1, 1, 9'h080, 4'h0, "jump_force");
    cyc(9'h0A0, 1, 9'h0A0, 0, 9'h000, 0, 4'h0, 1, 1, 1, 9'h1F0, 4'h0, "jump_alloc");
    cyc(9'h0A0, 0, 9'h000, 0, 9'h000, 0, 4'h0, 1, 1, 1, 9'h1F0, 4'h0, "jump_st_nt");

    do_reset();
    model_reset();
    for (int n = 0; n < 150; n++) begin
      logic [8:0] lpc, upc, utg, etg;
      logic       uv, ut, uj, eh, et;
      int         li;
      lpc = ($urandom_range(0, 3) == 0) ? 9'({7'($urandom_range(0, 127)), 2'b00})
                                        : pool[$urandom_range(0, 7)];
      upc = pool[$urandom_range(0, 7)];
      utg = 9'({7'($urandom_range(0, 127)), 2'b00});
      uv  = 1'($urandom_range(0, 1));
      ut  = ($urandom_range(0, 3) != 0);
      uj  = ($urandom_range(0, 7) == 0);
      li  = int'(lpc[5:2]);
      eh  = m_v[li] && (m_tag[li] == lpc[8:6]);
      et  = eh && m_c[li][1];
      etg = et ? m_tg[li] : lpc + 9'd4;
      cyc(lpc, uv, upc, ut, utg, uj, 4'h0, 1, eh, et, etg, 4'h0, "rand");
      if (uv) model_update(upc, ut, utg, uj);
    end
`endif

    if (sb.size() != 0) check_val("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PC_W, default 9, meaning program-counter width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16, meaning number of predictor table entries; it must be a power of two and at least 2.
REQ-003 SHALL have parameter GHR_W, default 4, meaning global history length, legal range 1..IDX_W, where IDX_W = $clog2(ENTRIES).
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port if_pc, input, PC_W bits: fetch-stage PC being looked up.
REQ-007 SHALL have port pred_hit, output, 1 bit: valid entry with matching tag for if_pc.
REQ-008 SHALL have port pred_taken, output, 1 bit: predict redirect.
REQ-009 SHALL have port pred_target, output, PC_W bits: predicted next PC.
REQ-010 SHALL have port pred_ghr, output, GHR_W bits: history used for this lookup, carried down the pipe by the datapath.
REQ-011 SHALL have port upd_valid, input, 1 bit: EX-stage resolution of a branch or jump this cycle.
REQ-012 SHALL have port upd_pc, input, PC_W bits: PC of the resolved instruction.
REQ-013 SHALL have port upd_taken, input, 1 bit: actual outcome.
REQ-014 SHALL have port upd_target, input, PC_W bits: actual target.
REQ-015 SHALL have port upd_is_jump, input, 1 bit: instruction is JAL/JALR rather than a conditional branch.
REQ-016 SHALL have port upd_ghr, input, GHR_W bits: pred_ghr value returned with the instruction.

Function
REQ-017 SHALL compute index = if_pc[IDX_W+1:2] and tag = if_pc[PC_W-1:IDX_W+2], with the tag 0 bits wide handled when PC_W = IDX_W+2.
REQ-018 Each entry SHALL hold a valid bit, a tag, a PC_W-bit target and a 2-bit saturating counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
REQ-019 Lookup SHALL be combinational from registered table state, giving zero-cycle latency: pred_hit = valid && tag match, pred_taken = pred_hit && ctr[1], pred_target = entry target when pred_taken, else if_pc+4 modulo 2^PC_W.
REQ-020 On upd_valid with a tag hit, the counter SHALL increment if taken and decrement if not taken, saturating at 11 and 00, and the target SHALL be overwritten only when taken.
REQ-021 On upd_valid with a miss and taken, the entry SHALL be allocated or replaced: valid=1, tag and target written, ctr=10, or ctr=11 if upd_is_jump.
REQ-022 On upd_valid with a miss and not taken, the table SHALL be left unchanged.
REQ-023 On upd_valid with upd_is_jump and a hit, the counter SHALL be forced to 11.
REQ-024 When a lookup and an update hit the same index in the same cycle, the lookup SHALL return pre-update state; the update is visible the next cycle.
REQ-025 With upd_valid=0, table and GHR SHALL hold.

Reset
REQ-026 While reset=1 at a clock edge, all valid bits SHALL clear, all counters SHALL become 01, all targets and tags SHALL become 0, and GHR SHALL become 0; an update in the same cycle as reset SHALL be ignored.
REQ-027 After reset, outputs SHALL be pred_hit=0, pred_taken=0, pred_target=if_pc+4 and pred_ghr=0.

Configuration
REQ-028 Macro BP_GSHARE_EN SHALL select the indexing scheme.
REQ-029 With BP_GSHARE_EN defined: lookup index SHALL be the REQ-017 index XOR zero-extended GHR; update index SHALL use upd_ghr; GHR SHALL shift left inserting upd_taken on each upd_valid with upd_is_jump=0; pred_ghr = GHR.
REQ-030 Without BP_GSHARE_EN: there SHALL be no GHR register, pred_ghr SHALL be tied to 0, upd_ghr SHALL be ignored, and indexing SHALL follow REQ-017 only.

Structure
REQ-031 The bp_entry_t struct typedef and the constants BP_CTR_SNT/WNT/WT/ST SHALL live in the shared Pipe_Buf_Reg_PKG package; the GHR width shall not be defined there.
REQ-032 The 2-bit saturating update SHALL be one combinational sub-module, bp_sat_ctr (inputs ctr, taken, force_st; output next ctr); the table SHALL be flops, not inferred RAM.

Verification
REQ-033 Reset, then lookup if_pc=0x010 SHALL give pred_hit=0, pred_taken=0, pred_target=0x014.
REQ-034 Update pc=0x010, taken, target=0x040, then lookup 0x010 next cycle SHALL give hit=1, taken=1, target=0x040; two not-taken updates SHALL then give taken=0 with hit=1.
REQ-035 Four taken updates to one entry followed by one not-taken SHALL still predict taken (saturation at 11, then 10).
REQ-036 Update pc=0x010 taken, then update pc=0x050 (same index, different tag) taken with target 0x100: lookup 0x010 SHALL miss and lookup 0x050 SHALL return 0x100.
REQ-037 Lookup and update to 0x010 in the same cycle on an empty table SHALL give hit=0 that cycle and hit=1 the next cycle.
REQ-038 With BP_GSHARE_EN: updates taken, not-taken, taken SHALL give GHR=4'b0101, and an entry trained with upd_ghr=0101 SHALL be hit only when the lookup GHR equals 0101.
